// File: rtl/ddr_weight_fetch_pkg.sv
// Shared constants and FSM encoding for the DDR weight fetch read master.
package ddr_weight_fetch_pkg;
    localparam int BEATS_PER_TILE = 81;
    localparam int BYTES_PER_BEAT = 32;
    localparam int BEAT_SHIFT     = 5;
    localparam int BOUNDARY_4K    = 4096;
    localparam int BEATS_PER_4K   = BOUNDARY_4K / BYTES_PER_BEAT;
    localparam int LEN_W          = 9;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        ADDR = S_ADDR,
        DATA = S_DATA,
        DONE = S_DONE
    } state_e;
endpackage

// File: rtl/ddr_burst_len_calc.sv
// Burst length = min(BURST_LEN, remaining beats, beats left before the next 4 KB boundary).
module ddr_burst_len_calc
    import ddr_weight_fetch_pkg::*;
#(
    parameter int REM_W     = 15,
    parameter int BURST_LEN = 16
) (
    input  logic [REM_W-1:0] remaining_i,
    input  logic [11:0]      addr_lo_i,
    output logic [LEN_W-1:0] len_o
);
    logic [LEN_W-1:0] to_bnd;
    logic [LEN_W-1:0] rem_c;

    always_comb begin
        to_bnd = LEN_W'(BEATS_PER_4K) - LEN_W'(addr_lo_i[11:BEAT_SHIFT]);
        rem_c  = (remaining_i > REM_W'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(remaining_i);
        len_o  = (to_bnd < rem_c) ? to_bnd : rem_c;
    end
endmodule

// File: rtl/ddr_weight_fetch.sv
// DDR read master: splits a tile fetch into single-outstanding read bursts and
// forwards every returned beat to the memory top with one cycle of latency.
module ddr_weight_fetch
    import ddr_weight_fetch_pkg::*;
#(
    parameter int DDR_RD_WIDTH   = 256,
    parameter int ADDR_WIDTH     = 32,
    parameter int TILE_CNT_WIDTH = 8,
    parameter int BURST_LEN      = 16
) (
    input  logic                      sys_clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [TILE_CNT_WIDTH-1:0] tile_num,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [ADDR_WIDTH-1:0]     ddr_araddr,
    output logic [7:0]                ddr_arlen,
    output logic                      ddr_arvalid,
    input  logic                      ddr_arready,
    input  logic [DDR_RD_WIDTH-1:0]   ddr_rdata,
    input  logic                      ddr_rvalid,
    input  logic                      ddr_rlast,
    output logic                      ddr_rready,
    output logic [DDR_RD_WIDTH-1:0]   DDR_data_out,
    output logic                      DDR_valid_out
);
    localparam int TOT_W = TILE_CNT_WIDTH + 7;

    state_e                    state_q;
    logic [TOT_W-1:0]          rem_q, rem_d, total, calc_rem;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d, araddr_q;
    logic [11:0]               calc_lo;
    logic [LEN_W-1:0]          len, len_q, cnt_q;
    logic [7:0]                arlen_q;
    logic                      busy_q, done_q, err_q, arvalid_q, rready_q, valid_q;
    logic [DDR_RD_WIDTH-1:0]   data_q;

    assign total = TOT_W'(tile_num) * TOT_W'(BEATS_PER_TILE);

    // In IDLE the calculator looks at the incoming command so the first burst
    // is ready on the accept edge; afterwards it tracks the running pointer.
    assign calc_lo  = (state_q == IDLE) ? base_addr[11:0] : addr_q[11:0];
    assign calc_rem = (state_q == IDLE) ? total : rem_q;
    assign addr_d   = addr_q + (ADDR_WIDTH'(len_q) << BEAT_SHIFT);
    assign rem_d    = rem_q - TOT_W'(len_q);

    ddr_burst_len_calc #(
        .REM_W     (TOT_W),
        .BURST_LEN (BURST_LEN)
    ) u_len (
        .remaining_i (calc_rem),
        .addr_lo_i   (calc_lo),
        .len_o       (len)
    );

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            valid_q <= ddr_rvalid && rready_q;
            if (ddr_rvalid && rready_q)
                data_q <= ddr_rdata;

            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        err_q  <= 1'b0;
                        addr_q <= base_addr;
                        rem_q  <= total;
                        if (total == '0) begin
                            state_q <= DONE;
                        end else begin
                            state_q   <= ADDR;
                            arvalid_q <= 1'b1;
                            araddr_q  <= base_addr;
                            arlen_q   <= 8'(len - LEN_W'(1));
                            len_q     <= len;
                        end
                    end
                end
                ADDR: begin
                    if (ddr_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt_q     <= '0;
                        addr_q    <= addr_d;
                        rem_q     <= rem_d;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (ddr_rvalid) begin
                        // Counter saturates at len; an overrun beat flags err and we keep waiting for rlast.
                        if (cnt_q != len_q)
                            cnt_q <= cnt_q + LEN_W'(1);
                        else if (!ddr_rlast)
                            err_q <= 1'b1;
                        if (ddr_rlast) begin
                            if ((cnt_q + LEN_W'(1)) != len_q)
                                err_q <= 1'b1;
                            rready_q <= 1'b0;
                            if (rem_q != '0) begin
                                state_q   <= ADDR;
                                arvalid_q <= 1'b1;
                                araddr_q  <= addr_q;
                                arlen_q   <= 8'(len - LEN_W'(1));
                                len_q     <= len;
                            end else begin
                                state_q <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign ddr_araddr    = araddr_q;
    assign ddr_arlen     = arlen_q;
    assign ddr_arvalid   = arvalid_q;
    assign ddr_rready    = rready_q;
    assign DDR_data_out  = data_q;
    assign DDR_valid_out = valid_q;
endmodule

// File: tb/tb_ddr_weight_fetch.sv
// Bench for ddr_weight_fetch: behavioural DDR slave, expected bursts and beats
// derived from the fetch rules with plain arithmetic.
module tb_ddr_weight_fetch;
    logic         sys_clk = 1'b0;
    logic         rstn = 1'b1;
    logic         start = 1'b0;
    logic [31:0]  base_addr = '0;
    logic [7:0]   tile_num = '0;
    logic         busy, done, err;
    logic [31:0]  ddr_araddr;
    logic [7:0]   ddr_arlen;
    logic         ddr_arvalid;
    logic         ddr_arready = 1'b0;
    logic [255:0] ddr_rdata = '0;
    logic         ddr_rvalid = 1'b0;
    logic         ddr_rlast = 1'b0;
    logic         ddr_rready;
    logic [255:0] DDR_data_out;
    logic         DDR_valid_out;

    always #5 sys_clk = ~sys_clk;

    ddr_weight_fetch dut (
        .sys_clk(sys_clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .tile_num(tile_num), .busy(busy), .done(done), .err(err),
        .ddr_araddr(ddr_araddr), .ddr_arlen(ddr_arlen), .ddr_arvalid(ddr_arvalid),
        .ddr_arready(ddr_arready), .ddr_rdata(ddr_rdata), .ddr_rvalid(ddr_rvalid),
        .ddr_rlast(ddr_rlast), .ddr_rready(ddr_rready),
        .DDR_data_out(DDR_data_out), .DDR_valid_out(DDR_valid_out)
    );

    int total = 0, bad = 0;
    logic [31:0] salt = 32'h1234_5678;
    int  ar_stall = 0;
    bit  rnd_mode = 1'b0;
    int  cut_burst = -1, cut_beats = 0;

    logic [31:0]  log_addr[$];
    logic [7:0]   log_len[$];
    logic [255:0] got[$];
    logic [31:0]  m_addr[$];
    int           m_len[$];
    int  done_cnt = 0, unstable = 0, stall_cnt = 0, cyc = 0, last_vo_cyc = 0, done_cyc = 0;
    bit  arv_seen = 1'b0;

    // slave bookkeeping: values seen/driven at the previous negedge
    bit          act = 1'b0;
    logic [31:0] b_addr = '0;
    int          b_idx = 0, b_len = 0, ar_cnt = 0;
    logic        p_arv = 0, p_ardy = 0, p_rvld = 0, p_rrdy = 0, p_rlast = 0;
    logic [31:0] p_araddr = '0;
    logic [7:0]  p_arlen = '0;

    function automatic logic [255:0] beat_data(input logic [31:0] a);
        return {8{a ^ salt}};
    endfunction

    task automatic model(input logic [31:0] base, input int tiles);
        int rem, l, bnd;
        logic [31:0] a;
        m_addr.delete(); m_len.delete();
        rem = tiles * 81; a = base;
        while (rem > 0) begin
            l = (rem < 16) ? rem : 16;
            bnd = (4096 - int'(a % 32'd4096)) / 32;
            if (bnd < l) l = bnd;
            m_addr.push_back(a); m_len.push_back(l);
            a += 32'(l * 32); rem -= l;
        end
    endtask

    function automatic int burst_diffs();
        int n = (log_addr.size() == m_addr.size()) ? 0 : 1;
        for (int i = 0; i < m_addr.size() && i < log_addr.size(); i++)
            if (log_addr[i] !== m_addr[i] || int'(log_len[i]) + 1 != m_len[i]) n++;
        return n;
    endfunction

    function automatic int beat_diffs();
        int k = 0, n = 0, nb;
        for (int i = 0; i < m_addr.size(); i++) begin
            nb = (i == cut_burst) ? cut_beats : m_len[i];
            for (int j = 0; j < nb; j++) begin
                if (k >= got.size() || got[k] !== beat_data(m_addr[i] + 32'(j * 32))) n++;
                k++;
            end
        end
        if (k != got.size()) n++;
        return n;
    endfunction

    always @(negedge sys_clk) begin
        if (!rstn) begin
            ddr_arready = 0; ddr_rvalid = 0; ddr_rlast = 0; ddr_rdata = '0;
            act = 0; ar_cnt = 0; p_arv = 0; p_ardy = 0; p_rvld = 0; p_rrdy = 0; p_rlast = 0;
        end else begin
            cyc++;
            if (p_rvld && p_rrdy) begin
                b_idx++;
                if (p_rlast) act = 0;
            end
            if (p_arv && p_ardy) begin
                log_addr.push_back(p_araddr); log_len.push_back(p_arlen);
                act = 1; b_addr = p_araddr; b_idx = 0;
                b_len = (log_addr.size() - 1 == cut_burst) ? cut_beats : int'(p_arlen) + 1;
            end
            if (p_arv && !p_ardy) begin
                stall_cnt++;
                if (ddr_arvalid !== 1'b1 || ddr_araddr !== p_araddr || ddr_arlen !== p_arlen) unstable++;
            end
            if (ddr_arvalid) arv_seen = 1;
            if (DDR_valid_out) begin got.push_back(DDR_data_out); last_vo_cyc = cyc; end
            if (done) begin done_cnt++; done_cyc = cyc; end

            ar_cnt = ddr_arvalid ? ar_cnt + 1 : 0;
            ddr_arready = ddr_arvalid && (ar_cnt > ar_stall) && (!rnd_mode || $urandom_range(0, 1) == 1);
            if (act) begin
                ddr_rvalid = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                ddr_rdata  = beat_data(b_addr + 32'(b_idx * 32));
                ddr_rlast  = (b_idx == b_len - 1);
            end else begin
                ddr_rvalid = 0; ddr_rlast = 0;
            end
            p_arv = ddr_arvalid; p_araddr = ddr_araddr; p_arlen = ddr_arlen; p_ardy = ddr_arready;
            p_rvld = ddr_rvalid; p_rrdy = ddr_rready; p_rlast = ddr_rlast;
        end
    end

    task automatic run_cmd(input logic [31:0] b, input int t, input int extra_at, output bit to);
        got.delete(); log_addr.delete(); log_len.delete();
        done_cnt = 0; unstable = 0; stall_cnt = 0; arv_seen = 0;
        @(negedge sys_clk); start = 1; base_addr = b; tile_num = 8'(t);
        @(negedge sys_clk); start = 0;
        to = 1;
        for (int i = 0; i < 4000; i++) begin
            if (done_cnt != 0) begin to = 0; break; end
            start = (extra_at != 0 && i == extra_at);
            if (start) begin base_addr = 32'h0004_0000; tile_num = 8'd3; end
            @(negedge sys_clk);
        end
        start = 0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        rstn = 1; #2 rstn = 0;
        repeat (3) @(negedge sys_clk);
        total++; if ({busy, done, err, ddr_arvalid, ddr_rready, DDR_valid_out} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 000000", {busy, done, err, ddr_arvalid, ddr_rready, DDR_valid_out}); end
        total++; if (ddr_araddr !== 32'h0) begin bad++; $display("FAIL reset_araddr: got %h want 0", ddr_araddr); end
        total++; if (ddr_arlen !== 8'h0) begin bad++; $display("FAIL reset_arlen: got %h want 0", ddr_arlen); end
        total++; if (DDR_data_out !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", DDR_data_out); end
        rstn = 1;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_single_tile();
        bit to;
        salt = $urandom; ar_stall = 0; rnd_mode = 0; cut_burst = -1;
        model(32'h0, 1); run_cmd(32'h0, 1, 0, to);
        total++; if (to) begin bad++; $display("FAIL single_timeout: done not seen"); end
        total++; if (burst_diffs() != 0) begin bad++; $display("FAIL single_bursts: diffs %0d want 0", burst_diffs()); end
        total++; if (log_addr.size() != 6 || log_addr[5] !== 32'hA00 || log_len[5] !== 8'd0) begin
            bad++; $display("FAIL single_last_burst: n=%0d want 6 at 0xA00 len 0", log_addr.size()); end
        total++; if (got.size() != 81) begin bad++; $display("FAIL single_beats: got %0d want 81", got.size()); end
        total++; if (beat_diffs() != 0) begin bad++; $display("FAIL single_data: diffs %0d want 0", beat_diffs()); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL single_done: got %0d want 1", done_cnt); end
        total++; if (done_cyc - last_vo_cyc != 1) begin
            bad++; $display("FAIL single_done_lat: got %0d want 1", done_cyc - last_vo_cyc); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", err); end
    endtask

    task automatic test_two_tiles();
        bit to;
        salt = $urandom;
        model(32'h0, 2); run_cmd(32'h0, 2, 0, to);
        total++; if (to) begin bad++; $display("FAIL two_timeout: done not seen"); end
        total++; if (log_addr.size() != 11 || log_addr[10] !== 32'h1400 || log_len[10] !== 8'd1) begin
            bad++; $display("FAIL two_last_burst: n=%0d want 11 ending 0x1400 len 1", log_addr.size()); end
        total++; if (burst_diffs() != 0) begin bad++; $display("FAIL two_bursts: diffs %0d want 0", burst_diffs()); end
        total++; if (got.size() != 162) begin bad++; $display("FAIL two_beats: got %0d want 162", got.size()); end
        total++; if (beat_diffs() != 0) begin bad++; $display("FAIL two_data: diffs %0d want 0", beat_diffs()); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL two_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_4k_split();
        bit to;
        salt = $urandom;
        model(32'h0FC0, 1); run_cmd(32'h0FC0, 1, 0, to);
        total++; if (to) begin bad++; $display("FAIL split_timeout: done not seen"); end
        total++; if (log_addr.size() < 2 || log_addr[0] !== 32'h0FC0 || log_len[0] !== 8'd1) begin
            bad++; $display("FAIL split_first: got %h/%0d want 0fc0/1", log_addr[0], log_len[0]); end
        total++; if (log_addr.size() < 2 || log_addr[1] !== 32'h1000 || log_len[1] !== 8'd15) begin
            bad++; $display("FAIL split_second: got %h/%0d want 1000/15", log_addr[1], log_len[1]); end
        total++; if (got.size() != 81) begin bad++; $display("FAIL split_beats: got %0d want 81", got.size()); end
        total++; if (burst_diffs() != 0 || beat_diffs() != 0) begin
            bad++; $display("FAIL split_model: bursts %0d data %0d want 0/0", burst_diffs(), beat_diffs()); end
    endtask

    task automatic test_arready_stall();
        bit to;
        logic [31:0] b;
        salt = $urandom; ar_stall = 10;
        b = $urandom & 32'h00FF_FFE0;
        model(b, 1); run_cmd(b, 1, 0, to);
        total++; if (to) begin bad++; $display("FAIL stall_timeout: done not seen"); end
        total++; if (unstable != 0) begin bad++; $display("FAIL stall_stable: changes %0d want 0", unstable); end
        total++; if (stall_cnt != 10 * m_addr.size()) begin
            bad++; $display("FAIL stall_cycles: got %0d want %0d", stall_cnt, 10 * m_addr.size()); end
        total++; if (burst_diffs() != 0 || beat_diffs() != 0) begin
            bad++; $display("FAIL stall_model: bursts %0d data %0d want 0/0", burst_diffs(), beat_diffs()); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL stall_done: got %0d want 1", done_cnt); end
        ar_stall = 0;
    endtask

    task automatic test_early_rlast();
        bit to;
        salt = $urandom; cut_burst = 0; cut_beats = 8;
        model(32'h0, 1); run_cmd(32'h0, 1, 0, to);
        total++; if (to) begin bad++; $display("FAIL early_timeout: done not seen"); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL early_err: got %b want 1", err); end
        total++; if (got.size() != 73) begin bad++; $display("FAIL early_beats: got %0d want 73", got.size()); end
        total++; if (burst_diffs() != 0 || beat_diffs() != 0) begin
            bad++; $display("FAIL early_model: bursts %0d data %0d want 0/0", burst_diffs(), beat_diffs()); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL early_done: got %0d want 1", done_cnt); end
        cut_burst = -1;
        model(32'h2000, 1); run_cmd(32'h2000, 1, 0, to);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL early_err_clear: got %b want 0", err); end
        total++; if (to || beat_diffs() != 0) begin bad++; $display("FAIL early_next_data: diffs %0d want 0", beat_diffs()); end
    endtask

    task automatic test_zero_tiles();
        log_addr.delete(); done_cnt = 0; arv_seen = 0;
        @(negedge sys_clk); start = 1; base_addr = 32'h40; tile_num = 8'd0;
        @(negedge sys_clk); start = 0;
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL zero_enter: busy %b done %b want 1 0", busy, done); end
        @(negedge sys_clk);
        total++; if (busy !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL zero_done: busy %b done %b want 1 1", busy, done); end
        @(negedge sys_clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL zero_idle: busy %b done %b want 0 0", busy, done); end
        repeat (3) @(negedge sys_clk);
        total++; if (arv_seen || done_cnt != 1) begin bad++; $display("FAIL zero_noreq: arv %b done %0d want 0 1", arv_seen, done_cnt); end
    endtask

    task automatic test_start_while_busy();
        bit to;
        salt = $urandom;
        model(32'h3000, 1); run_cmd(32'h3000, 1, 20, to);
        repeat (20) @(negedge sys_clk);
        total++; if (to) begin bad++; $display("FAIL busy_timeout: done not seen"); end
        total++; if (burst_diffs() != 0) begin bad++; $display("FAIL busy_bursts: diffs %0d want 0", burst_diffs()); end
        total++; if (beat_diffs() != 0) begin bad++; $display("FAIL busy_data: diffs %0d want 0", beat_diffs()); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL busy_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_random();
        bit to;
        logic [31:0] b;
        int t;
        rnd_mode = 1;
        for (int it = 0; it < 6; it++) begin
            salt = $urandom; ar_stall = $urandom_range(0, 3);
            b = $urandom & 32'hFFFF_FFE0; t = $urandom_range(0, 3);
            model(b, t); run_cmd(b, t, 0, to);
            total++; if (to) begin bad++; $display("FAIL rand_timeout: it %0d", it); end
            total++; if (burst_diffs() != 0) begin bad++; $display("FAIL rand_bursts: it %0d diffs %0d want 0", it, burst_diffs()); end
            total++; if (beat_diffs() != 0) begin bad++; $display("FAIL rand_data: it %0d diffs %0d want 0", it, beat_diffs()); end
            total++; if (done_cnt != 1 || err !== 1'b0) begin
                bad++; $display("FAIL rand_done: it %0d done %0d err %b want 1 0", it, done_cnt, err); end
        end
        rnd_mode = 0; ar_stall = 0;
    endtask

    task automatic test_reset_mid_data();
        bit to, hit;
        salt = $urandom;
        got.delete(); log_addr.delete(); log_len.delete(); done_cnt = 0;
        @(negedge sys_clk); start = 1; base_addr = 32'h0; tile_num = 8'd2;
        @(negedge sys_clk); start = 0;
        hit = 0;
        for (int i = 0; i < 500; i++) begin
            if (got.size() >= 20 && ddr_rready) begin hit = 1; break; end
            @(negedge sys_clk);
        end
        total++; if (!hit) begin bad++; $display("FAIL rst_reach_data: not reached"); end
        #2 rstn = 0;
        #1;
        total++; if ({busy, done, err, ddr_arvalid, ddr_rready, DDR_valid_out} !== 6'b0 ||
                     ddr_araddr !== 32'h0 || ddr_arlen !== 8'h0 || DDR_data_out !== '0) begin
            bad++; $display("FAIL rst_async: ctrl %b araddr %h arlen %h want all 0",
                {busy, done, err, ddr_arvalid, ddr_rready, DDR_valid_out}, ddr_araddr, ddr_arlen); end
        @(negedge sys_clk); @(negedge sys_clk); rstn = 1;
        repeat (30) @(negedge sys_clk);
        total++; if (done_cnt != 0) begin bad++; $display("FAIL rst_no_done: got %0d want 0", done_cnt); end
        model(32'h100, 1); run_cmd(32'h100, 1, 0, to);
        total++; if (to || beat_diffs() != 0 || done_cnt != 1) begin
            bad++; $display("FAIL rst_recover: diffs %0d done %0d want 0 1", beat_diffs(), done_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_two_tiles();
        test_4k_split();
        test_arready_stall();
        test_early_rlast();
        test_zero_tiles();
        test_start_while_busy();
        test_random();
        test_reset_mid_data();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ddr_weight_fetch.md
Name: ddr_weight_fetch

Overview:
DDR read master directly upstream of the weight/feature memory top. It turns a start command (base address, tile count) into AXI-style read bursts and forwards each returned 256-bit beat as a data/valid stream (DDR_data_out/DDR_valid_out). That stream drives the memory top's DDR_data_in/DDR_valid_in. One tile is 81 beats, matching the 81x256 to 64x324 width conversion downstream.

Parameters:
DDR_RD_WIDTH, 256, data beat width in bits (32 bytes per beat).
ADDR_WIDTH, 32, byte address width.
BEATS_PER_TILE, 81, beats per tile.
TILE_CNT_WIDTH, 8, width of tile_num.
BURST_LEN, 16, maximum beats per burst (power of 2, at most 256).

Ports:
sys_clk  in  1  system clock, 100 MHz; the only clock.
rstn  in  1  asynchronous active-low reset.
start  in  1  one-cycle command pulse; accepted only in IDLE.
base_addr  in  ADDR_WIDTH  start byte address; bits [4:0] must be 0.
tile_num  in  TILE_CNT_WIDTH  number of tiles to fetch.
busy  out  1  high from start acceptance through the DONE cycle.
done  out  1  one-cycle pulse when the command completes.
err  out  1  sticky burst-length mismatch flag; cleared on start acceptance.
ddr_araddr  out  ADDR_WIDTH  burst start byte address.
ddr_arlen  out  8  burst beats minus 1.
ddr_arvalid  out  1  address request valid.
ddr_arready  in  1  address accepted.
ddr_rdata  in  DDR_RD_WIDTH  read data.
ddr_rvalid  in  1  read data valid.
ddr_rlast  in  1  last beat of burst.
ddr_rready  out  1  read data ready.
DDR_data_out  out  DDR_RD_WIDTH  beat to the memory top.
DDR_valid_out  out  1  beat valid; there is no backpressure.

Behaviour:
- Reset: state IDLE. busy, done, err, ddr_arvalid, ddr_rready and DDR_valid_out are 0. ddr_araddr, ddr_arlen and DDR_data_out are 0.
- Accepting a command (start in IDLE):
  - total = tile_num*BEATS_PER_TILE (width TILE_CNT_WIDTH+7); remaining = total; cur_addr = base_addr; err = 0.
  - If total = 0: go to DONE; no request is issued.
  - Otherwise go to ADDR.
- start outside IDLE is ignored.
- Each ADDR entry computes len = min(BURST_LEN, remaining, beats to the next 4 KB boundary), where beats to boundary = (4096 - cur_addr[11:0])/32.
- ADDR: ddr_arvalid = 1, ddr_araddr = cur_addr, ddr_arlen = len-1.
  - araddr, arlen and arvalid stay stable until ddr_arready.
  - On the handshake cycle: go to DATA, set beat counter = 0, cur_addr += len*32, remaining -= len.
- DATA: ddr_rready = 1. Only one burst is outstanding at a time.
  - Each rvalid beat increments the beat counter.
  - Burst ends on rlast. err is set if the beat count including the rlast beat differs from len.
  - A beat arriving with counter = len and no rlast also sets err; the block keeps waiting for rlast.
  - After rlast: go to ADDR if remaining > 0, else DONE.
- DONE: done = 1 for exactly one cycle, then IDLE; busy falls with it.
- Data path: DDR_data_out <= ddr_rdata and DDR_valid_out <= 1 on every rvalid&&rready cycle; otherwise DDR_valid_out <= 0.
  - Latency is 1 cycle.
  - DDR_data_out holds its last value when not valid.
  - Beats are forwarded even when err is flagged.
- Beat order equals address order; the output count per command equals total when the slave is well-behaved.
- Reset mid-operation: all state is cleared immediately and no done pulse is issued. The DDR controller shares rstn, so dropping ddr_arvalid under reset is permitted.

Decomposition:
- Shared package holds: BEATS_PER_TILE (81), BYTES_PER_BEAT (32), the 4 KB boundary constant, and the FSM state encoding (IDLE, ADDR, DATA, DONE) as localparams.
- One sub-module, ddr_burst_len_calc: combinational min of BURST_LEN, remaining and beats-to-boundary. It is kept separate so it can be unit-tested on its own.

Test Plan:
- tile_num=1, base 0x0, arready=1, rvalid continuous:
  - bursts at 0x000, 0x200, 0x400, 0x600, 0x800 with arlen=15, then 0xA00 with arlen=0.
  - 81 DDR_valid_out pulses; done 1 cycle after the last output beat; err=0.
- tile_num=2, base 0x0:
  - 162 beats as 10 bursts of arlen 15 plus one of arlen 1 at 0x1400.
  - done once.
- 4 KB split, base 0x0FC0, tile_num=1:
  - first burst araddr 0x0FC0, arlen=1.
  - next araddr 0x1000, arlen=15.
  - 81 beats total.
- arready held 0 for 10 cycles:
  - arvalid stays 1 with araddr/arlen unchanged.
  - then normal completion.
- Slave asserts rlast on beat 8 of a 16-beat burst:
  - err=1, 8 beats forwarded, fetch continues and done still pulses.
  - err clears on the next accepted start.
- tile_num=0 → done 1 cycle after DONE entry, arvalid never asserted.
- start pulsed while busy → ignored, no extra bursts.
- rstn low mid-DATA → all outputs 0 in the same cycle.
